// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with DEPTH slots, valid/ready flow control, flush and bubble collapse.
// Define PIPE_STAGE_REG_SKID_EN to add a one-entry skid buffer so ready_o no longer depends on ready_i.
module pipe_stage_reg #(
   parameter  int CTRL_W = 8,
   parameter  int DATA_W = 128,
   parameter  int DEPTH  = 1,
   localparam int CNT_W  = $clog2(DEPTH + 2)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q [DEPTH];
   logic [CTRL_W-1:0] ctrl_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   logic [DEPTH-1:0]  adv;
   logic              s0_room;
   logic              in_xfer;
   logic              out_xfer;
   logic              load0;
   logic [CTRL_W-1:0] src_ctrl;
   logic [DATA_W-1:0] src_data;

   // Walk from the output slot back to slot 0: a slot may move on when the slot ahead has room.
   always_comb begin : advance_chain
      logic room;
      adv  = '0;
      // NOTE: blocking '=' here because 'room' is a running value re-read on the next iteration.
      room = ready_i;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         adv[k] = valid_q[k] & room;
         room   = ~valid_q[k] | room;
      end
      s0_room = room;
   end

`ifdef PIPE_STAGE_REG_SKID_EN
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;

   assign ready_o  = ~rst_i & ~skid_valid_q;
   assign in_xfer  = valid_i & ready_o & ~flush_i;
   assign load0    = s0_room & ~flush_i & (skid_valid_q | in_xfer);
   assign src_ctrl = skid_valid_q ? skid_ctrl_q : ctrl_i;
   assign src_data = skid_valid_q ? skid_data_q : data_i;

   always_comb begin
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (flush_i || (skid_valid_q && s0_room)) begin
         skid_valid_d = 1'b0;
         skid_ctrl_d  = '0;
      end else if (in_xfer && !s0_room) begin
         skid_valid_d = 1'b1;
         skid_ctrl_d  = ctrl_i;
         skid_data_d  = data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
      end
   end
`else
   assign ready_o  = ~rst_i & s0_room;
   assign in_xfer  = valid_i & ready_o & ~flush_i;
   assign load0    = in_xfer;
   assign src_ctrl = ctrl_i;
   assign src_data = data_i;
`endif

   assign out_xfer = valid_q[DEPTH-1] & ready_i;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      // A slot that hands its entry on becomes a bubble; its data is left in place.
      for (int k = 0; k < DEPTH; k++) begin
         if (adv[k]) begin
            valid_d[k] = 1'b0;
            ctrl_d[k]  = '0;
         end
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (adv[k-1]) begin
            valid_d[k] = 1'b1;
            ctrl_d[k]  = ctrl_q[k-1];
            data_d[k]  = data_q[k-1];
         end
      end
      if (load0) begin
         valid_d[0] = 1'b1;
         ctrl_d[0]  = src_ctrl;
         data_d[0]  = src_data;
      end
      if (flush_i) begin
         valid_d = '0;
         for (int k = 0; k < DEPTH; k++) ctrl_d[k] = '0;
      end
   end

   always_comb begin
      count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
      if (flush_i) count_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         count_q <= '0;
         // NOTE: the slot storage is deliberately reset, data included, so data_o reads 0 out of reset.
         for (int k = 0; k < DEPTH; k++) begin
            ctrl_q[k] <= '0;
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign ctrl_o  = ctrl_q[DEPTH-1];
   assign data_o  = data_q[DEPTH-1];
   assign count_o = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the stage is modelled as an ordered queue of bounded capacity.
module tb_pipe_stage_reg;
   localparam int CTRL_W = 8;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 3;
   localparam int CNT_W  = $clog2(DEPTH + 2);
`ifdef PIPE_STAGE_REG_SKID_EN
   localparam int CAP  = DEPTH + 1;
   localparam bit SKID = 1'b1;
`else
   localparam int CAP  = DEPTH;
   localparam bit SKID = 1'b0;
`endif

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
      int                acc_cyc;
   } entry_t;

   logic              clk_i = 1'b0;
   logic              rst_i, valid_i, ready_o, flush_i, valid_o, ready_i;
   logic [CTRL_W-1:0] ctrl_i, ctrl_o;
   logic [DATA_W-1:0] data_i, data_o;
   logic [CNT_W-1:0]  count_o;

   entry_t sb_q[$];
   int     total = 0;
   int     bad   = 0;
   int     cyc   = 0;
   int     n_out = 0;
   bit     stream_mode = 1'b0;
   bit     mdl_ready;

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .ctrl_i(ctrl_i), .data_i(data_i), .flush_i(flush_i), .valid_o(valid_o),
      .ready_i(ready_i), .ctrl_o(ctrl_o), .data_o(data_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: mid-cycle, compare the output slot against the head of the expected queue.
   always @(negedge clk_i) begin
      mdl_ready = !rst_i && ((sb_q.size() < CAP) || (!SKID && ready_i));
      check("ready_o", ready_o, mdl_ready);
      check("count_o", count_o, sb_q.size());
      if (!valid_o) begin
         check("ctrl_o_on_bubble", ctrl_o, 0);
      end else if (sb_q.size() == 0) begin
         check("spurious_valid_o", valid_o, 0);
      end else begin
         check("ctrl_o", ctrl_o, sb_q[0].ctrl);
         check("data_o", data_o, sb_q[0].data);
         if (ready_i) begin
            if (stream_mode) check("stream_latency", cyc - sb_q[0].acc_cyc, DEPTH);
            void'(sb_q.pop_front());
            n_out++;
         end
      end
   end

   // Drive one cycle; once the monitor has looked, record what the block must have accepted.
   task automatic step(input bit r, input bit v, input bit f, input bit rdy,
                       input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      @(posedge clk_i); #1;
      rst_i = r; valid_i = v; flush_i = f; ready_i = rdy; ctrl_i = c; data_i = d;
      @(negedge clk_i); #1;
      if (r || f) sb_q.delete();
      else if (v && mdl_ready) sb_q.push_back('{ctrl: c, data: d, acc_cyc: cyc});
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) step(0, 0, 0, 1, '0, '0);
      check("drain_empty", sb_q.size(), 0);
   endtask

   initial begin
      int out0;
      rst_i = 1'b1; valid_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
      ctrl_i = 8'hFF; data_i = '1;

      // Reset held two cycles while an entry is offered.
      step(1, 1, 0, 0, 8'hFF, '1);
      step(1, 1, 0, 1, 8'hFF, '1);
      check("reset_valid_o", valid_o, 0);
      check("reset_ctrl_o", ctrl_o, 0);
      check("reset_data_o", data_o, 0);
      check("reset_count_o", count_o, 0);
      check("reset_ready_o", ready_o, 0);
      step(0, 0, 0, 1, '0, '0);
      check("ready_after_reset", ready_o, 1);

      // Back-to-back stream of data 1..10 with ready_i held high.
      out0 = n_out;
      stream_mode = 1'b1;
      for (int i = 1; i <= 10; i++) step(0, 1, 0, 1, 8'($urandom_range(1, 255)), DATA_W'(i));
      drain(30);
      stream_mode = 1'b0;
      check("stream_outputs", n_out - out0, 10);

      // Backpressure: offer more than fits while downstream stalls.
      out0 = n_out;
      for (int i = 0; i < CAP + 2; i++) step(0, 1, 0, 0, 8'($urandom), DATA_W'(100 + i));
      step(0, 0, 0, 0, '0, '0);
      check("bp_count_full", count_o, CAP);
      check("bp_ready_low", ready_o, 0);
      drain(30);
      check("bp_outputs", n_out - out0, CAP);

      // Bubble collapse: two entries separated by idle cycles during a stall.
      step(0, 1, 0, 0, 8'h5A, 32'h0000_000A);
      step(0, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      step(0, 1, 0, 0, 8'hC3, 32'h0000_000B);
      step(0, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, '0, '0);
      check("bubble_count", count_o, 2);
      drain(30);

      // Flush three held entries while a new one is offered.
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'($urandom_range(1, 255)), DATA_W'(200 + i));
      step(0, 0, 0, 0, '0, '0);
      check("pre_flush_count", count_o, 3);
      step(0, 1, 1, 0, 8'hEE, 32'hDEAD_BEEF);
      step(0, 0, 0, 0, '0, '0);
      check("flush_valid_o", valid_o, 0);
      check("flush_ctrl_o", ctrl_o, 0);
      check("flush_count_o", count_o, 0);
      drain(5);

      // Simultaneous in/out with every slot occupied.
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 8'($urandom), DATA_W'(300 + i));
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 1, 8'($urandom), DATA_W'(400 + i));
         check("full_count", count_o, DEPTH);
         check("full_ready", ready_o, 1);
      end
      drain(30);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
              $urandom_range(0, 9) < 6, 8'($urandom), $urandom);
      end
      drain(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
